// File: rtl/jac_intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets inside the
// CPU data-memory window and the request state encoding.
package jac_intc_pkg;

    localparam int OFS_ENABLE  = 0;
    localparam int OFS_PENDING = 1;
    localparam int OFS_STATUS  = 2;
    localparam int OFS_VEC     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/jac_int_ctrl_irq_sync.sv
// Two-flop synchroniser for one interrupt source plus a rising-edge detector
// on the synchronised level.
module irq_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // prev_q resets low, so a source already high at reset release reads as a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/jac_int_ctrl.sv
// Memory-mapped interrupt controller: per-channel enable/pending/vector
// registers, fixed lowest-index priority and a non-nesting IDLE/REQ/SERVICE handshake.
module jac_int_ctrl
    import jac_intc_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter logic [7:0]        BASE_ADDR = 8'd240,
    parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b1}}
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    input  logic [7:0]        addr,
    input  logic [7:0]        w_data,
    input  logic              w_en,
    output logic [7:0]        r_data,
    output logic              hit,
    input  logic [NUM_CH-1:0] irq_src,
    output logic              int_req,
    output logic [7:0]        int_vec,
    input  logic              int_ack,
    input  logic              int_ret,
    output state_e            dbg_state
);

    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LAST_OFS = OFS_VEC + NUM_CH - 1;

    logic [NUM_CH-1:0] sync_level;
    logic [NUM_CH-1:0] sync_rise;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        irq_sync u_sync (
            .clk_i   (wb_clk_i),
            .rst_ni  (reset_n),
            .async_i (irq_src[g]),
            .level_o (sync_level[g]),
            .rise_o  (sync_rise[g])
        );
    end

    // 9-bit offset: addresses below the base wrap far above LAST_OFS.
    logic [8:0] ofs;
    assign ofs = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign hit = (ofs <= 9'(LAST_OFS));

    logic              wr_enable;
    logic              wr_pending;
    logic [NUM_CH-1:0] vec_wr;

    assign wr_enable  = w_en && (ofs == 9'(OFS_ENABLE));
    assign wr_pending = w_en && (ofs == 9'(OFS_PENDING));

    always_comb begin
        vec_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            vec_wr[i] = w_en && (ofs == 9'(OFS_VEC + i));
        end
    end

    logic [NUM_CH-1:0] enable_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] clr;
    logic [7:0]        vec_q [NUM_CH];

    state_e            state_q;
    logic              int_req_q;
    logic [7:0]        int_vec_q;
    logic [IDX_W-1:0]  win_q;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_CH-1:0] req_vec;
    logic              any_req;

    always_comb begin
        req_vec = pending_q & enable_q;
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign any_req = |req_vec;

    // Edge channels: a new rise beats a clear in the same cycle.
    always_comb begin
        clr = '0;
        if (wr_pending) begin
            clr = w_data[NUM_CH-1:0];
        end
        if (state_q == ST_REQ && int_ack) begin
            clr[win_q] = 1'b1;
        end
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = (pending_q[i] & ~clr[i]) | sync_rise[i];
            end else begin
                pending_d[i] = sync_level[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            enable_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            if (wr_enable) begin
                enable_q <= w_data[NUM_CH-1:0];
            end
            pending_q <= pending_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (vec_wr[i]) begin
                    vec_q[i] <= w_data;
                end
            end
        end
    end

    // Vector is captured on entry to REQ, so later VEC writes wait for the next request.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            int_vec_q <= '0;
            win_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q   <= ST_REQ;
                        win_q     <= win_idx;
                        int_vec_q <= vec_q[win_idx];
                        int_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q   <= ST_SERVICE;
                        int_req_q <= 1'b0;
                    end else if (!enable_q[win_q] || !pending_q[win_q]) begin
                        state_q   <= ST_IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (int_ret) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_req   = int_req_q;
    assign int_vec   = int_vec_q;
    assign dbg_state = state_q;

    always_comb begin
        r_data = '0;
        if (hit) begin
            if (ofs == 9'(OFS_ENABLE)) begin
                r_data = 8'(enable_q);
            end else if (ofs == 9'(OFS_PENDING)) begin
                r_data = 8'(pending_q);
            end else if (ofs == 9'(OFS_STATUS)) begin
                r_data = {(state_q == ST_SERVICE), 4'b0000, 3'(win_q)};
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ofs == 9'(OFS_VEC + i)) begin
                        r_data = vec_q[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jac_int_ctrl.sv
// Directed bench for jac_int_ctrl: channel 1 is a level channel, the rest are
// edge channels; every request vector is checked against a scoreboard queue.
module tb_jac_int_ctrl;
    import jac_intc_pkg::*;

    localparam logic [7:0] A_EN   = 8'd240;
    localparam logic [7:0] A_PEND = 8'd241;
    localparam logic [7:0] A_STAT = 8'd242;
    localparam logic [7:0] A_VEC0 = 8'd243;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       hit;
    logic [3:0] irq_src;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_ack;
    logic       int_ret;
    state_e     dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    jac_int_ctrl #(
        .NUM_CH    (4),
        .BASE_ADDR (8'd240),
        .EDGE_MASK (4'b1101)
    ) dut (
        .wb_clk_i  (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .w_data    (w_data),
        .w_en      (w_en),
        .r_data    (r_data),
        .hit       (hit),
        .irq_src   (irq_src),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .int_ret   (int_ret),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every new request must present the next expected vector.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (int_req === 1'b1 && req_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req_vec", int_vec, 256);
            end else begin
                chk("req_vec", int_vec, exp_q.pop_front());
            end
        end
        req_prev = int_req;
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        addr = a; w_data = d; w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic rd(string name, logic [7:0] a, logic [7:0] exp);
        addr = a;
        #1;
        chk(name, r_data, exp);
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic do_ret();
        int_ret = 1'b1;
        @(negedge clk);
        int_ret = 1'b0;
    endtask

    task automatic pulse_src(logic [3:0] m);
        irq_src = m;
        @(negedge clk);
        irq_src = 4'b0000;
    endtask

    task automatic wait_req(string name);
        int n = 0;
        while (int_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, int_req, 1);
    endtask

    task automatic expect_quiet(string name, int cycles);
        int saw = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (int_req !== 1'b0) saw = 1;
        end
        chk(name, saw, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n = 1'b0; addr = '0; w_data = '0; w_en = 1'b0;
        irq_src = '0; int_ack = 1'b0; int_ret = 1'b0;
        tick(2);

        // Reset state and address window
        chk("rst_int_req", int_req, 0);
        chk("rst_int_vec", int_vec, 0);
        chk("rst_state", int'(dbg_state), int'(ST_IDLE));
        rd("rst_enable", A_EN, 8'h00);
        rd("rst_status", A_STAT, 8'h00);
        chk("hit_base", hit, 1);
        addr = 8'd239; #1; chk("hit_below", hit, 0);
        addr = 8'd246; #1; chk("hit_top", hit, 1);
        addr = 8'd247; #1; chk("hit_above", hit, 0);
        chk("rdata_outside", r_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);

        // Single edge request: latency, VEC write during REQ, ignored ret, ack
        wr(A_EN, 8'h01);
        wr(A_VEC0, 8'h40);
        exp_q.push_back(8'h40);
        addr = A_PEND;
        irq_src = 4'b0001;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) irq_src = 4'b0000;
            if (c == 2) chk("t1_pend_early", r_data, 8'h00);
            if (c == 3) chk("t1_pend_set", r_data, 8'h01);
            if (int_req === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("t1_latency", lat, 4);
        rd("t1_status_req", A_STAT, 8'h00);
        wr(A_VEC0, 8'h41);
        chk("t1_vec_stable", int_vec, 8'h40);
        rd("t1_vec0_written", A_VEC0, 8'h41);
        do_ret();
        chk("t1_ret_ignored", int'(dbg_state), int'(ST_REQ));
        do_ack();
        chk("t1_req_dropped", int_req, 0);
        chk("t1_state_svc", int'(dbg_state), int'(ST_SERVICE));
        rd("t1_status_svc", A_STAT, 8'h80);
        rd("t1_pend_cleared", A_PEND, 8'h00);
        do_ret();
        chk("t1_state_idle", int'(dbg_state), int'(ST_IDLE));
        rd("t1_status_idle", A_STAT, 8'h00);

        // Priority: channels 1 (level) and 2 (edge) together
        wr(A_EN, 8'hFF);
        rd("t2_enable_masked", A_EN, 8'h0F);
        wr(A_VEC0 + 8'd1, 8'h51);
        wr(A_VEC0 + 8'd2, 8'h62);
        wr(A_VEC0 + 8'd3, 8'h73);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h62);
        irq_src = 4'b0110;
        wait_req("t2_first_req");
        do_ack();
        rd("t2_status_ch1", A_STAT, 8'h81);
        irq_src = 4'b0000;
        tick(4);
        do_ret();
        wait_req("t2_second_req");
        chk("t2_vec2", int_vec, 8'h62);
        do_ack();
        rd("t2_status_ch2", A_STAT, 8'h82);
        do_ret();

        // No nesting: channel 3 waits for ret
        exp_q.push_back(8'h41);
        pulse_src(4'b0001);
        wait_req("t3_req_ch0");
        do_ack();
        exp_q.push_back(8'h73);
        pulse_src(4'b1000);
        expect_quiet("t3_quiet_in_svc", 8);
        rd("t3_pend_ch3", A_PEND, 8'h08);
        int_ret = 1'b1;
        @(negedge clk);
        int_ret = 1'b0;
        chk("t3_ret_edge_req", int_req, 0);
        @(negedge clk);
        chk("t3_req_after_ret", int_req, 1);
        chk("t3_vec3", int_vec, 8'h73);
        do_ack();
        do_ret();

        // Withdrawal by disabling the winner
        exp_q.push_back(8'h41);
        pulse_src(4'b0001);
        wait_req("t4_req_ch0");
        wr(A_EN, 8'h00);
        @(negedge clk);
        chk("t4_withdrawn", int_req, 0);
        chk("t4_state_idle", int'(dbg_state), int'(ST_IDLE));
        do_ack();
        chk("t4_ack_ignored", int'(dbg_state), int'(ST_IDLE));
        rd("t4_pend_kept", A_PEND, 8'h01);
        wr(A_PEND, 8'h01);
        rd("t4_pend_w1c", A_PEND, 8'h00);

        // Level channel re-requests while held
        wr(A_EN, 8'h0F);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h51);
        irq_src = 4'b0010;
        wait_req("t5_req_level");
        do_ack();
        wr(A_PEND, 8'h02);
        rd("t5_w1c_no_effect", A_PEND, 8'h02);
        do_ret();
        wait_req("t5_rereq");
        do_ack();
        irq_src = 4'b0000;
        tick(4);
        rd("t5_pend_released", A_PEND, 8'h00);
        do_ret();
        expect_quiet("t5_no_more_req", 8);

        // Asynchronous reset in REQ
        exp_q.push_back(8'h41);
        pulse_src(4'b0001);
        wait_req("t6_req_ch0");
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_req_async_drop", int_req, 0);
        chk("t6_state_idle", int'(dbg_state), int'(ST_IDLE));
        chk("t6_vec_zero", int_vec, 0);
        rd("t6_enable", A_EN, 8'h00);
        rd("t6_pending", A_PEND, 8'h00);
        rd("t6_status", A_STAT, 8'h00);
        rd("t6_vec0", A_VEC0, 8'h00);
        rd("t6_vec1", A_VEC0 + 8'd1, 8'h00);
        rd("t6_vec2", A_VEC0 + 8'd2, 8'h00);
        rd("t6_vec3", A_VEC0 + 8'd3, 8'h00);

        // Source already high at release counts as a rising edge
        irq_src = 4'b0001;
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        rd("t7_pend_from_release", A_PEND, 8'h01);
        wr(A_VEC0, 8'h99);
        exp_q.push_back(8'h99);
        wr(A_EN, 8'h01);
        wait_req("t7_req");
        do_ack();
        irq_src = 4'b0000;
        do_ret();

        tick(4);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jac_int_ctrl.md
JAC_INT_CTRL -- requirements
Module: jac_int_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of interrupt channels, legal range 1..8.
REQ-002 Parameter BASE_ADDR, default 8'd240, first data-memory address of the register window.
REQ-003 Parameter EDGE_MASK, default all ones, per-channel mode: 1 = rising-edge, 0 = level-high.
REQ-004 Port wb_clk_i, input, 1, sole clock; all state on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port addr, input, 8, CPU data address (rs_data).
REQ-007 Port w_data, input, 8, CPU write data (rd_data).
REQ-008 Port w_en, input, 1, CPU data-memory write strobe.
REQ-009 Port r_data, output, 8, combinational read data for the addressed register; 0 outside the window.
REQ-010 Port hit, output, 1, combinational; high when addr is in [BASE_ADDR, BASE_ADDR+2+NUM_CH].
REQ-011 Port irq_src, input, NUM_CH, asynchronous interrupt sources.
REQ-012 Port int_req, output, 1, registered interrupt request to the CPU.
REQ-013 Port int_vec, output, 8, registered jump vector of the requesting channel.
REQ-014 Port int_ack, input, 1, one-cycle pulse; CPU has taken the interrupt.
REQ-015 Port int_ret, input, 1, one-cycle pulse; CPU executed return-from-interrupt.

Function
REQ-016 Register map: BASE+0 ENABLE (R/W, bit i enables channel i); BASE+1 PENDING (read; write-1-to-clear, edge channels only); BASE+2 STATUS (read: bit7 = in service, bits2:0 = active channel); BASE+3+i VEC[i] (R/W).
REQ-017 Writes take effect at the rising edge where w_en=1 and addr matches; bits at or above NUM_CH are ignored on write and read as 0.
REQ-018 Each irq_src bit passes through a two-flop synchroniser; edge channels set PENDING[i] on a synchronised 0->1 transition; PENDING[i] of a level channel equals its synchronised level.
REQ-019 When the same edge-channel bit is both set and write-1-cleared in one cycle, set wins.
REQ-020 State machine IDLE, REQ, SERVICE.
REQ-021 IDLE -> REQ when any PENDING&ENABLE bit is set; lowest index wins; the winner's index is latched and int_vec <= VEC[winner], int_req <= 1 at the same edge.
REQ-022 In REQ, int_vec stays constant; a later higher-priority arrival does not preempt.
REQ-023 REQ -> SERVICE on int_ack: int_req <= 0; the winner's PENDING bit is cleared (edge channels); STATUS bit7 <= 1.
REQ-024 REQ -> IDLE with int_req <= 0 if, before int_ack, the winner's ENABLE or PENDING bit becomes 0; int_ack and the withdrawal in the same cycle: int_ack wins.
REQ-025 SERVICE -> IDLE on int_ret; STATUS bit7 <= 0; no nesting: pending interrupts wait in SERVICE.
REQ-026 int_ack outside REQ and int_ret outside SERVICE are ignored.
REQ-027 Latency: a source rising before edge k gives PENDING set after edge k+2 and int_req high after edge k+3 (IDLE, enabled).
REQ-028 Writing VEC[winner] during REQ does not change int_vec until the next request.

Reset
REQ-029 reset_n low asynchronously forces IDLE, int_req=0, int_vec=0, ENABLE=0, PENDING=0, all VEC=0, synchronisers=0, STATUS=0.
REQ-030 Reset during REQ or SERVICE drops int_req immediately with no ack; the first edge after release samples irq_src from the synchroniser reset value, so a source already high at release is treated as a rising edge.

Structure
REQ-031 Package jac_intc_pkg holds the register offsets (OFS_ENABLE, OFS_PENDING, OFS_STATUS, OFS_VEC) and the state encoding.
REQ-032 Sub-module irq_sync (two-flop synchroniser plus edge detector, one per channel) is instantiated NUM_CH times.

Verification
REQ-033 Write ENABLE=0x01, VEC[0]=0x40; pulse irq_src[0] -> int_req=1 and int_vec=0x40 exactly 4 edges later; int_ack -> int_req=0 and STATUS=0x80.
REQ-034 ENABLE=0x0F, raise irq_src[2] and irq_src[1] together -> int_vec=VEC[1]; after ack+ret -> second request with VEC[2].
REQ-035 In SERVICE, pulse irq_src[3] -> no int_req until int_ret; one edge after ret, int_req=1 with VEC[3].
REQ-036 In REQ for channel 0, write ENABLE=0x00 -> int_req=0 next edge, state IDLE; int_ack the following cycle is ignored.
REQ-037 Level channel (EDGE_MASK bit1=0) held high -> re-requests after every ret; write-1-clear to PENDING has no effect; release the source -> no further request.
REQ-038 Assert reset_n=0 mid-REQ -> int_req=0 without a clock edge; all registers read 0.
